cic_interp_gen: RTL

CIC_INTERP_GEN -- requirements
Module: cic_interp_gen

---
 rtl/cic_pkg.sv | 27 ++
 rtl/cic_lane.sv | 67 ++++++
 rtl/cic_interp_gen.sv | 96 +++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolator: width derivation,
// rate clamping and legal parameter limits.
package cic_pkg;

  localparam int ORDER_MIN = 1;
  localparam int ORDER_MAX = 8;
  localparam int RMAX_MIN  = 1;

  function automatic int cbits_of(
    input int ibits,
    input int gbits
  );
    return ibits + gbits;
  endfunction

  function automatic int unsigned clamp_rate(
    input int unsigned rate,
    input int unsigned rmax
  );
    if (rate == 0)
      return 1;
    if (rate > rmax)
      return rmax;
    return rate;
  endfunction

endpackage

// File: rtl/cic_lane.sv
// One comb + integrator chain for a single sample component,
// with half-up rounding and positive saturation on the output.
module cic_lane
  import cic_pkg::*;
#(
  parameter int ORDER = 5,
  parameter int IBITS = 20,
  parameter int OBITS = 20,
  parameter int CBITS = 54
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clock_en,
  input  logic                    boundary,
  input  logic signed [IBITS-1:0] x,
  output logic signed [OBITS-1:0] y
);

  localparam int LSB = CBITS - OBITS;
  localparam logic signed [OBITS-1:0] MAXP =
    {1'b0, {(OBITS-1){1'b1}}};

  logic signed [CBITS-1:0] cx  [ORDER+1];
  logic signed [CBITS-1:0] cdx [ORDER];
  logic signed [CBITS-1:0] acc [ORDER];
  logic signed [CBITS-1:0] acc_in;
  logic signed [OBITS-1:0] win;
  logic signed [OBITS-1:0] y_nxt;

  // zero stuffing: comb output enters only once per frame
  assign acc_in = boundary ? cx[ORDER] : '0;
  assign win    = acc[ORDER-1][CBITS-1 -: OBITS];

  if (LSB > 0) begin : g_rnd
    logic rbit;
    assign rbit  = acc[ORDER-1][LSB-1];
    assign y_nxt = (rbit && win != MAXP)
                 ? win + OBITS'(1) : win;
  end else begin : g_trunc
    assign y_nxt = win;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= ORDER; k++)
        cx[k] <= '0;
      for (int k = 0; k < ORDER; k++) begin
        cdx[k] <= '0;
        acc[k] <= '0;
      end
      y <= '0;
    end else if (clock_en) begin
      if (boundary) begin
        cx[0] <= CBITS'(x);
        for (int k = 0; k < ORDER; k++) begin
          cx[k+1] <= cx[k] - cdx[k];
          cdx[k]  <= cx[k];
        end
      end
      acc[0] <= acc[0] + acc_in;
      for (int k = 1; k < ORDER; k++)
        acc[k] <= acc[k] + acc[k-1];
      y <= y_nxt;
    end
  end

endmodule

// File: rtl/cic_interp_gen.sv
// Complex CIC interpolator: shared rate/frame control driving
// two identical comb+integrator lanes (real and imaginary).
module cic_interp_gen
  import cic_pkg::*;
#(
  parameter int ORDER = 5,
  parameter int RMAX  = 320,
  parameter int RBITS = 9,
  parameter int IBITS = 20,
  parameter int OBITS = 20,
  parameter int GBITS = 34
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clock_en,
  input  logic [RBITS-1:0]        rate,
  output logic                    req,
  input  logic signed [IBITS-1:0] x_real,
  input  logic signed [IBITS-1:0] x_imag,
  output logic signed [OBITS-1:0] y_real,
  output logic signed [OBITS-1:0] y_imag,
  output logic                    y_valid
);

  localparam int CBITS = cbits_of(IBITS, GBITS);
  localparam int ORD_C =
    (ORDER < ORDER_MIN) ? ORDER_MIN :
    (ORDER > ORDER_MAX) ? ORDER_MAX : ORDER;
  localparam int RMAX_C = (RMAX < RMAX_MIN) ? RMAX_MIN : RMAX;

  // rate is kept as r_act-1 so RMAX == 2^RBITS still fits
  logic [RBITS-1:0] cnt;
  logic [RBITS-1:0] rm1_q;
  logic [RBITS-1:0] rm1_new;
  logic [RBITS-1:0] rm1;
  logic             loaded;
  logic             boundary;

  assign rm1_new  = RBITS'(clamp_rate(32'(rate), RMAX_C) - 32'd1);
  assign rm1      = loaded ? rm1_q : rm1_new;
  assign boundary = clock_en && (cnt == rm1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      rm1_q   <= '0;
      loaded  <= 1'b0;
      req     <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      req     <= boundary;
      y_valid <= clock_en;
      if (!loaded) begin
        loaded <= 1'b1;
        rm1_q  <= rm1_new;
      end
      if (clock_en) begin
        if (boundary) begin
          cnt   <= '0;
          rm1_q <= rm1_new;
        end else begin
          cnt <= cnt + RBITS'(1);
        end
      end
    end
  end

  cic_lane #(
    .ORDER (ORD_C),
    .IBITS (IBITS),
    .OBITS (OBITS),
    .CBITS (CBITS)
  ) u_lane_re (
    .clock    (clock),
    .reset    (reset),
    .clock_en (clock_en),
    .boundary (boundary),
    .x        (x_real),
    .y        (y_real)
  );

  cic_lane #(
    .ORDER (ORD_C),
    .IBITS (IBITS),
    .OBITS (OBITS),
    .CBITS (CBITS)
  ) u_lane_im (
    .clock    (clock),
    .reset    (reset),
    .clock_en (clock_en),
    .boundary (boundary),
    .x        (x_imag),
    .y        (y_imag)
  );

endmodule
